// File: rtl/ysyx_201979054_axi_read_arbiter.sv
// Round-robin arbiter sharing one AXI4 read channel between icache refill (0),
// dcache refill (1) and non-cacheable load (2). One burst in flight at a time.
module ysyx_201979054_axi_read_arbiter #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  arst,
  input  logic [2:0]            i_req,
  input  logic [ADDR_WIDTH-1:0] i_addr_0,
  input  logic [ADDR_WIDTH-1:0] i_addr_1,
  input  logic [ADDR_WIDTH-1:0] i_addr_2,
  input  logic [7:0]            i_len_0,
  input  logic [7:0]            i_len_1,
  input  logic [7:0]            i_len_2,
  input  logic [2:0]            i_size_0,
  input  logic [2:0]            i_size_1,
  input  logic [2:0]            i_size_2,
  output logic [2:0]            o_grant,
  output logic [2:0]            o_r_valid,
  output logic [DATA_WIDTH-1:0] o_r_data,
  output logic                  o_r_last,
  output logic [2:0]            o_done,
  output logic                  o_r_err,
  output logic                  o_len_err,
  output logic                  o_ar_valid,
  input  logic                  i_ar_ready,
  output logic [ADDR_WIDTH-1:0] o_ar_addr,
  output logic [7:0]            o_ar_len,
  output logic [2:0]            o_ar_size,
  output logic [1:0]            o_ar_burst,
  input  logic                  i_r_valid,
  input  logic [DATA_WIDTH-1:0] i_r_data,
  input  logic [1:0]            i_r_resp,
  input  logic                  i_r_last,
  output logic                  o_r_ready
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_e;

  state_e                  state_q;
  logic [1:0]              owner_q;
  logic [1:0]              last_owner_q;
  logic [2:0]              grant_q;
  logic                    ar_valid_q;
  logic                    r_ready_q;
  logic [ADDR_WIDTH-1:0]   ar_addr_q;
  logic [7:0]              ar_len_q;
  logic [2:0]              ar_size_q;
  logic [7:0]              beat_cnt_q;

  logic [1:0]              cand0_s;
  logic [1:0]              cand1_s;
  logic [1:0]              cand2_s;
  logic [3:0]              req_ext_s;
  logic [1:0]              owner_d;
  logic [ADDR_WIDTH-1:0]   ar_addr_d;
  logic [7:0]              ar_len_d;
  logic [2:0]              ar_size_d;
  logic                    beat_s;

  function automatic logic [1:0] next_port(input logic [1:0] p);
    logic [1:0] n;
    case (p)
      2'd0:    n = 2'd1;
      2'd1:    n = 2'd2;
      default: n = 2'd0;
    endcase
    return n;
  endfunction

  function automatic logic [2:0] port_onehot(input logic [1:0] p);
    logic [2:0] oh;
    case (p)
      2'd0:    oh = 3'b001;
      2'd1:    oh = 3'b010;
      2'd2:    oh = 3'b100;
      default: oh = 3'b000;
    endcase
    return oh;
  endfunction

  // Round-robin winner: search starts one past the previous owner.
  always_comb begin
    req_ext_s = {1'b0, i_req};
    cand0_s   = next_port(last_owner_q);
    cand1_s   = next_port(cand0_s);
    cand2_s   = next_port(cand1_s);
    if (req_ext_s[cand0_s]) begin
      owner_d = cand0_s;
    end else if (req_ext_s[cand1_s]) begin
      owner_d = cand1_s;
    end else begin
      owner_d = cand2_s;
    end
  end

  // AR field mux for the winning requester.
  always_comb begin
    case (owner_d)
      2'd0: begin
        ar_addr_d = i_addr_0;
        ar_len_d  = i_len_0;
        ar_size_d = i_size_0;
      end
      2'd1: begin
        ar_addr_d = i_addr_1;
        ar_len_d  = i_len_1;
        ar_size_d = i_size_1;
      end
      2'd2: begin
        ar_addr_d = i_addr_2;
        ar_len_d  = i_len_2;
        ar_size_d = i_size_2;
      end
      default: begin
        ar_addr_d = '0;
        ar_len_d  = 8'd0;
        ar_size_d = 3'd0;
      end
    endcase
  end

  assign beat_s = r_ready_q & i_r_valid;

  // Arbitration FSM; last_owner resets to 2 so port 0 is searched first.
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      state_q      <= IDLE;
      owner_q      <= 2'd0;
      last_owner_q <= 2'd2;
      grant_q      <= 3'b000;
      ar_valid_q   <= 1'b0;
      r_ready_q    <= 1'b0;
      ar_addr_q    <= '0;
      ar_len_q     <= 8'd0;
      ar_size_q    <= 3'd0;
      beat_cnt_q   <= 8'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|i_req) begin
            owner_q    <= owner_d;
            grant_q    <= port_onehot(owner_d);
            ar_addr_q  <= ar_addr_d;
            ar_len_q   <= ar_len_d;
            ar_size_q  <= ar_size_d;
            ar_valid_q <= 1'b1;
            state_q    <= ADDR;
          end
        end
        ADDR: begin
          if (i_ar_ready) begin
            ar_valid_q <= 1'b0;
            r_ready_q  <= 1'b1;
            beat_cnt_q <= 8'd0;
            state_q    <= DATA;
          end
        end
        DATA: begin
          if (beat_s) begin
            beat_cnt_q <= beat_cnt_q + 8'd1;
            if (i_r_last) begin
              r_ready_q    <= 1'b0;
              grant_q      <= 3'b000;
              last_owner_q <= owner_q;
              state_q      <= IDLE;
            end
          end
        end
        default: begin
          state_q    <= IDLE;
          grant_q    <= 3'b000;
          ar_valid_q <= 1'b0;
          r_ready_q  <= 1'b0;
        end
      endcase
    end
  end

  assign o_grant    = grant_q;
  assign o_ar_valid = ar_valid_q;
  assign o_ar_addr  = ar_addr_q;
  assign o_ar_len   = ar_len_q;
  assign o_ar_size  = ar_size_q;
  assign o_ar_burst = 2'b01;
  assign o_r_ready  = r_ready_q;

  // Beat-side strobes are combinational so beats reach the owner with no latency;
  // the counter holds beats already taken, so the last beat must see it equal ARLEN.
  assign o_r_data  = i_r_data;
  assign o_r_last  = i_r_last;
  assign o_r_valid = beat_s ? grant_q : 3'b000;
  assign o_done    = (beat_s && i_r_last) ? grant_q : 3'b000;
  assign o_r_err   = beat_s & (i_r_resp != 2'b00);
  assign o_len_err = beat_s & i_r_last & (beat_cnt_q != ar_len_q);

endmodule

// File: doc/ysyx_201979054_axi_read_arbiter.md
# ysyx_201979054_axi_read_arbiter

Shares the core's single AXI4 read channel between three requesters: instruction cache refill (port 0), data cache refill (port 1) and non-cacheable/MMIO load (port 2). It grants one requester at a time using round-robin priority and drives the AR channel from the granted requester's address, length and size. It routes R beats back to the granted requester and releases the channel on the last beat. It sits between the cache/non-cacheable FSMs and the AXI master port, replacing the OR-ed start-read signalling.

## Interface
- ADDR_WIDTH, 64, AXI address width
- DATA_WIDTH, 32, AXI read data width
- clk  input  1  clock, all state on rising edge
- arst  input  1  asynchronous, active-low reset
- i_req  input  3  per-requester read request, level; held until o_done of that port
- i_addr_0 / i_addr_1 / i_addr_2  input  ADDR_WIDTH  start address per requester
- i_len_0 / i_len_1 / i_len_2  input  8  AXI ARLEN per requester (beats−1)
- i_size_0 / i_size_1 / i_size_2  input  3  AXI ARSIZE per requester
- o_grant  output  3  one-hot current owner; 0 when idle
- o_r_valid  output  3  per-requester beat strobe
- o_r_data  output  DATA_WIDTH  shared read data (i_r_data pass-through)
- o_r_last  output  1  last beat indicator (i_r_last pass-through)
- o_done  output  3  per-requester completion strobe
- o_r_err  output  1  beat with RRESP != OKAY
- o_len_err  output  1  RLAST beat count mismatch with ARLEN
- o_ar_valid  output  1  AXI ARVALID
- i_ar_ready  input  1  AXI ARREADY
- o_ar_addr  output  ADDR_WIDTH  AXI ARADDR
- o_ar_len  output  8  AXI ARLEN
- o_ar_size  output  3  AXI ARSIZE
- o_ar_burst  output  2  AXI ARBURST, constant 2'b01 (INCR)
- i_r_valid  input  1  AXI RVALID
- i_r_data  input  DATA_WIDTH  AXI RDATA
- i_r_resp  input  2  AXI RRESP
- i_r_last  input  1  AXI RLAST
- o_r_ready  output  1  AXI RREADY

## Operation
- FSM states: IDLE, ADDR, DATA.
- IDLE:
  - If i_req != 0, select the winner by round-robin. Search order starts at (last_owner+1) mod 3.
  - Register the owner, its addr/len/size into AR registers, and go to ADDR.
  - If i_req == 0, stay in IDLE.
- ADDR: o_ar_valid=1 and the AR fields are stable. On i_ar_ready go to DATA, and clear the beat counter.
- DATA: o_r_ready=1.
  - Each i_r_valid cycle is a beat. o_r_valid[owner]=1; other bits 0.
  - The beat counter increments per beat. It is 8-bit and wraps at 255; only reachable with len=255.
  - On beat with i_r_last:
    - o_done[owner]=1.
    - o_len_err=1 if beat count != stored len.
    - last_owner←owner; go to IDLE.
- o_r_err = beat & (i_r_resp != 2'b00). The burst continues to RLAST regardless.
- AR outputs come from registers only. Requester inputs changing after grant have no effect.
- A requester deasserting i_req mid-transaction is ignored; the burst runs to completion and o_done still pulses.
- i_req of the owner still high in the IDLE cycle after o_done is treated as a new request. Requesters drop i_req in the cycle after o_done.
- Beats arriving in IDLE/ADDR are not accepted (o_r_ready=0).
- Reset (any state, mid-burst included):
  - State→IDLE, last_owner←2 so port 0 wins first.
  - o_grant=0, o_ar_valid=0, o_r_ready=0, o_r_valid=0, o_done=0, o_r_err=0, o_len_err=0, o_ar_addr/len/size=0, counter=0.
  - The in-flight AXI burst is abandoned; the AXI slave is reset by the same arst.

## Timing
- i_req rising at cycle N (IDLE) → o_ar_valid and o_grant at N+1.
- AR handshake at cycle M → o_r_ready at M+1.
- o_r_valid, o_r_data, o_r_last, o_done, o_r_err and o_len_err are combinational from R inputs. There is zero-cycle latency on beats.
- Last beat at cycle K → IDLE at K+1, next o_ar_valid at K+2 earliest. This gives one mandatory idle cycle between bursts.
- o_grant is held from the AR phase through the last beat and drops at K+1.
- Worst-case wait for a continuously requesting port is two full bursts.

## Test plan
- Single icache request, addr 0x8000_0000, len 3, size 2, ARREADY after 2 cycles, 4 back-to-back beats. Required:
  - o_ar_valid held 3 cycles.
  - o_r_valid[0] on 4 beats.
  - o_done[0] on beat 4.
  - o_grant=001 throughout, then 000.
- All three i_req asserted together after reset, each len 0. Required:
  - Grant order is port 0, 1, 2.
  - Each burst separated by exactly one idle cycle.
- Ports 1 and 2 held requesting continuously with len 1. Required:
  - Grants alternate 1, 2, 1, 2.
  - Port 0 is never granted.
- Data burst len 3 with RVALID gaps (valid on cycles 0, 2, 3, 6) and RRESP=SLVERR on beat 2. Required:
  - o_r_valid[1] only on those cycles.
  - o_r_err pulses once.
  - o_done[1] on beat 4 only.
- ARLEN 3 but RLAST on beat 2. Required:
  - o_len_err=1 with o_done on that beat.
  - Return to IDLE.
- arst asserted mid-DATA (after beat 1 of 4). Required:
  - All outputs 0 immediately.
  - After release, a pending port-2 request wins only if port 0 is idle (port 0 first in priority).
